regwrite_demux32: RTL and testbench
===================================

# regwrite_demux32

Write-back distributor for the 32-entry register file: the one-to-many counterpart of the register-file read selectors. It accepts a single write-back request stream, buffers up to two requests, and steers each one to exactly one register via a registered one-hot write enable with a broadcast data bus. It also keeps a pending-write scoreboard, set at issue and cleared at write-back, so the decode stage can detect read-after-write hazards.

## Interface
Parameters:
- DEPTH, 2, buffer entries (fixed at 2; count width is 2 bits)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low; sampled on the rising edge of clock
- in_valid  in  1  write-back request present
- in_ready  out  1  buffer can accept; combinational, equals (count != 2)
- in_addr  in  5  destination register
- in_data  in  32  write data
- hold  in  1  register file write port unavailable; blocks draining
- reserve_valid  in  1  issue stage claims a destination
- reserve_addr  in  5  register being claimed
- we  out  32  one-hot registered write enable, all-zero when idle
- waddr  out  5  registered address of the current write
- wdata  out  32  registered data of the current write
- busy  out  32  scoreboard; bit i=1 means register i has a pending write
- count  out  2  buffered entries, 0..2

## Operation
- Buffer: 2-entry FIFO with head/tail pointers that wrap mod 2. count encodes the state: EMPTY (0), ONE (1), FULL (2).
- Push: occurs when in_valid & in_ready. Pop: occurs when count != 0 & !hold.
- State transitions:
  - EMPTY to ONE on push.
  - ONE to FULL on push without pop.
  - ONE stays ONE on push with pop.
  - ONE to EMPTY on pop without push.
  - FULL to ONE on pop (push is impossible while full).
- Pop: loads waddr and wdata from the head, and sets we = decode(head addr). If the head addr is 0, we stays all-zero (r0 is hardwired), but waddr and wdata are still loaded.
- No pop in a cycle: we = 0 on the next edge. waddr and wdata hold their values.
- Scoreboard, evaluated per edge:
  - reserve_valid with addr != 0 sets busy[addr].
  - A pop of addr != 0 clears busy[addr].
  - Reserve and pop on the same addr in the same cycle: reserve wins, busy stays 1.
  - busy[0] is always 0.
  - Reserving an already-busy register leaves it busy.
- Requests are accepted in order; no reordering and no coalescing of same-address writes.

## Timing
- Reset (resetn low at an edge):
  - count=0, pointers=0, we=0, waddr=0, wdata=0, busy=0.
  - in_ready reads 1 after the reset edge.
  - Inputs are ignored in any cycle where resetn is sampled low.
  - Reset mid-operation discards all buffered entries and pending busy bits.
- Latency without bypass: request accepted at edge N is head during cycle N+1, pops at edge N+1, and we is high during cycle N+2.
- hold: each held cycle adds one cycle of latency. we is 0 while hold is sampled high. Entries are retained.
- Throughput: 1 write per cycle sustained when hold=0. in_ready drops only in FULL.
- we is high for exactly one cycle per popped nonzero-address entry.

## Configuration
- REGWRITE_BYPASS_EN defined:
  - When count=0, hold=0 and a push occurs, the request goes straight to the output registers at the same edge. The buffer is not written and count stays 0.
  - Latency is 1 (we high during cycle N+1). Scoreboard clear happens at that edge.
- REGWRITE_BYPASS_EN undefined: every request passes through the buffer, latency is always 2.

## Test plan
- Reset: drive resetn=0 with in_valid=1, addr=5 -> after release, count=0, we=0, busy=0, in_ready=1, and nothing is written.
- Single write: in_addr=7, data=0xDEADBEEF at edge N -> during N+2 (N+1 with REGWRITE_BYPASS_EN), we=0x00000080, waddr=7, wdata=0xDEADBEEF; high for one cycle only.
- Fill and hold:
  - Hold=1, push addr 3 then addr 4 -> count=2, in_ready=0, we=0.
  - Release hold -> we=0x8 then 0x10 on consecutive cycles; count returns to 0.
- r0 write: push addr 0, data 0x1234 -> we stays 0, waddr=0, busy[0]=0.
- Scoreboard:
  - Reserve addr 9 -> busy=0x200; the write-back pop of addr 9 clears it.
  - Reserve 9 in the same cycle as a pop of 9 -> busy[9] stays 1.
- Back-to-back: 4 consecutive pushes (addrs 1,2,3,4) with hold=0 -> in_ready stays 1 throughout; we shows 0x2, 0x4, 0x8, 0x10 on consecutive cycles.

Source files
------------

// File: rtl/regwrite_demux32.sv
// Write-back distributor: 2-entry request buffer steering each write to one
// register via a registered one-hot enable, plus a pending-write scoreboard.
// Optional same-edge bypass when idle: define REGWRITE_BYPASS_EN.

module regwrite_demux32_cell #(
  parameter int IDX = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic       rsv_en,
  input  logic [4:0] rsv_addr,
  output logic       we_bit,
  output logic       busy_bit
);
  localparam logic [4:0] ADDR = 5'(IDX);
  localparam logic       LIVE = (IDX != 0);  // r0 is hardwired: never written, never busy

  logic wr_hit, rsv_hit;
  assign wr_hit  = LIVE && wr_en && (wr_addr == ADDR);
  assign rsv_hit = LIVE && rsv_en && (rsv_addr == ADDR);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      we_bit   <= 1'b0;
      busy_bit <= 1'b0;
    end else begin
      we_bit <= wr_hit;
      // a claim in the same cycle as the retiring write keeps the register busy
      if (rsv_hit)     busy_bit <= 1'b1;
      else if (wr_hit) busy_bit <= 1'b0;
    end
  end
endmodule

module regwrite_demux32 #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        hold,
  input  logic        reserve_valid,
  input  logic [4:0]  reserve_addr,
  output logic [31:0] we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] busy,
  output logic [1:0]  count
);
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t mem [DEPTH];
  wb_req_t in_req, wr_req;
  logic    head, tail;
  logic    push, pop, bypass, buf_push, wr_en;

  assign in_req   = '{addr: in_addr, data: in_data};
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (count != 2'd0) && !hold;

`ifdef REGWRITE_BYPASS_EN
  assign bypass = push && (count == 2'd0) && !hold;
`else
  assign bypass = 1'b0;
`endif

  assign buf_push = push && !bypass;
  assign wr_en    = pop || bypass;
  assign wr_req   = pop ? mem[head] : in_req;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      waddr <= 5'd0;
      wdata <= 32'd0;
    end else begin
      if (buf_push) begin
        mem[tail] <= in_req;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + 2'(buf_push) - 2'(pop);
      if (wr_en) begin
        waddr <= wr_req.addr;
        wdata <= wr_req.data;
      end
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    regwrite_demux32_cell #(.IDX(i)) u_cell (
      .clock    (clock),
      .resetn   (resetn),
      .wr_en    (wr_en),
      .wr_addr  (wr_req.addr),
      .rsv_en   (reserve_valid),
      .rsv_addr (reserve_addr),
      .we_bit   (we[i]),
      .busy_bit (busy[i])
    );
  end
endmodule

// File: tb/tb_regwrite_demux32.sv
// Randomized + directed bench for regwrite_demux32; a queue-based reference
// model predicts post-edge outputs, a monitor compares them after each edge.
module tb_regwrite_demux32;
  logic        clock = 1'b0;
  logic        resetn, in_valid, in_ready, hold, reserve_valid;
  logic [4:0]  in_addr, reserve_addr, waddr;
  logic [31:0] in_data, we, wdata, busy;
  logic [1:0]  count;

  regwrite_demux32 dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] we, wdata, busy;
    logic [4:0]  waddr;
    logic [1:0]  count;
    logic        ready;
  } exp_t;

`ifdef REGWRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // reference state
  req_t        fifo[$];
  bit          m_busy[32];
  logic [31:0] m_we, m_wdata;
  logic [4:0]  m_waddr;
  exp_t        expq[$];

  int errors = 0, checks = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit   push, pop, wr;
    req_t w;
    int   n;
    logic [31:0] b;
    wr = 0;
    if (!resetn) begin
      fifo.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      n    = fifo.size();
      push = in_valid && (n != 2);
      pop  = (n != 0) && !hold;
      if (pop) begin
        w = fifo.pop_front(); wr = 1;
      end else if (BYP && push && n == 0 && !hold) begin
        w.addr = in_addr; w.data = in_data; wr = 1; push = 0;
      end
      if (push) fifo.push_back('{addr: in_addr, data: in_data});
      m_we = 0;
      if (wr) begin
        m_waddr = w.addr; m_wdata = w.data;
        if (w.addr != 0) begin
          m_we = 32'd1 << w.addr;
          m_busy[w.addr] = 0;
        end
      end
      if (reserve_valid && reserve_addr != 0) m_busy[reserve_addr] = 1;
    end
    b = 0;
    foreach (m_busy[i]) b[i] = m_busy[i];
    expq.push_back('{we: m_we, wdata: m_wdata, busy: b, waddr: m_waddr,
                     count: 2'(fifo.size()), ready: (fifo.size() != 2)});
  endtask

  task automatic cyc(input bit rst_n, input bit v, input logic [4:0] a, input logic [31:0] d,
                     input bit h, input bit rv, input logic [4:0] ra);
    @(negedge clock);
    resetn = rst_n; in_valid = v; in_addr = a; in_data = d; hold = h;
    reserve_valid = rv; reserve_addr = ra;
    model_step();
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("we", we, e.we);
        chk("waddr", {27'd0, waddr}, {27'd0, e.waddr});
        chk("wdata", wdata, e.wdata);
        chk("busy", busy, e.busy);
        chk("count", {30'd0, count}, {30'd0, e.count});
        chk("in_ready", {31'd0, in_ready}, {31'd0, e.ready});
      end else if (started) begin
        chk("expectation_queue_empty", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    resetn = 0; in_valid = 0; in_addr = 0; in_data = 0; hold = 0;
    reserve_valid = 0; reserve_addr = 0;
    // reset with a live request that must be ignored
    cyc(0, 1, 5, 32'h55, 0, 1, 5);
    cyc(0, 1, 5, 32'h55, 0, 0, 0);
    idle(2);
    // single write
    cyc(1, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    idle(3);
    // fill under hold, then release
    cyc(1, 1, 3, 32'h33, 1, 0, 0);
    cyc(1, 1, 4, 32'h44, 1, 0, 0);
    cyc(1, 1, 6, 32'h66, 1, 0, 0);   // refused while full
    cyc(1, 0, 0, 0, 1, 0, 0);
    idle(4);
    // r0 write
    cyc(1, 1, 0, 32'h1234, 0, 0, 0);
    idle(3);
    // scoreboard set and clear, and reserve colliding with the retiring write
    cyc(1, 0, 0, 0, 0, 1, 9);
    cyc(1, 1, 9, 32'h99, 0, 0, 0);
    idle(3);
    cyc(1, 1, 9, 32'h9A, 0, 1, 9);
    cyc(1, 0, 0, 0, 0, 1, 9);
    idle(3);
    // back-to-back
    for (int i = 1; i <= 4; i++) cyc(1, 1, 5'(i), 32'(i * 17), 0, 0, 0);
    idle(3);
    // mid-operation reset
    cyc(1, 1, 11, 32'hB, 1, 1, 12);
    cyc(1, 1, 13, 32'hD, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) < 6), 5'($urandom),
          $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), 5'($urandom));
    idle(4);
    @(posedge clock);
    #2;
    if (expq.size() != 0) chk("undrained_expectations", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
